// File: rtl/up_bus_bridge_if.sv
// Bus bundle between an Avalon-MM master and the up_* register bus.
// The bridge connects through the slave modport. A master, such as a JTAG
// agent together with its register decoder, connects through the master modport.
interface up_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic [1:0]        avs_response;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] up_addr;
    logic [DATA_W-1:0] up_data_wr;
    logic              up_wr;
    logic              up_rd;
    logic [DATA_W-1:0] up_data_rd;
    logic              up_wait;
    logic              busy;
    logic [7:0]        timeout_cnt;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, up_data_rd, up_wait,
        output avs_readdata, avs_response, avs_waitrequest, up_addr, up_data_wr,
               up_wr, up_rd, busy, timeout_cnt
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, up_data_rd, up_wait,
        input  avs_readdata, avs_response, avs_waitrequest, up_addr, up_data_wr,
               up_wr, up_rd, busy, timeout_cnt
    );
endinterface

// File: rtl/up_bus_bridge.sv
// Avalon-MM to up_* register bus transaction engine.
// It issues one-cycle rd/wr strobes and enforces a minimum read latency.
// It honours up_wait and aborts with SLAVEERROR when the wait counter reaches
// TIMEOUT. Aborted transactions are counted in a saturating 8-bit counter.
module up_bus_bridge #(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          RD_LATENCY   = 2,
    parameter int          TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input logic            up_clk,
    input logic            up_rst,
    up_bus_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    localparam logic [15:0]       RD_LAT_K  = 16'(RD_LATENCY);
    localparam logic [15:0]       TIMEOUT_K = 16'(TIMEOUT);
    localparam logic [DATA_W-1:0] TO_DATA   = DATA_W'(TIMEOUT_DATA);

    state_t            state_q, state_d;
    logic              opWrite_q, opWrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic [15:0]       k_q, k_d;
    logic [7:0]        tocnt_q, tocnt_d;
    logic              upWr_q, upWr_d;
    logic              upRd_q, upRd_d;

    logic [15:0]       kNow;
    logic [15:0]       minK;

    // kNow is the wait count for the current WAIT cycle. It is 1 on the first WAIT cycle.
    assign kNow = k_q + 16'd1;
    assign minK = opWrite_q ? 16'd1 : RD_LAT_K;

    // Next-state logic: accept a request, strobe, wait for completion or timeout, then report.
    always_comb begin
        state_d   = state_q;
        opWrite_d = opWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        k_d       = k_q;
        tocnt_d   = tocnt_q;
        upWr_d    = 1'b0;
        upRd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.avs_write) begin
                    opWrite_d = 1'b1;
                    addr_d    = bus.avs_address;
                    wdata_d   = bus.avs_writedata;
                    upWr_d    = 1'b1;
                    state_d   = STROBE;
                end else if (bus.avs_read) begin
                    opWrite_d = 1'b0;
                    addr_d    = bus.avs_address;
                    upRd_d    = 1'b1;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                k_d     = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                k_d = kNow;
                if (kNow >= minK && !bus.up_wait) begin
                    if (!opWrite_q) begin
                        rdata_d = bus.up_data_rd;
                    end
                    resp_d  = 2'b00;
                    state_d = DONE;
                end else if (kNow == TIMEOUT_K) begin
                    if (!opWrite_q) begin
                        rdata_d = TO_DATA;
                    end
                    resp_d = 2'b10;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. A synchronous reset abandons any transaction in flight.
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state_q   <= IDLE;
            opWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            k_q       <= 16'd0;
            tocnt_q   <= 8'd0;
            upWr_q    <= 1'b0;
            upRd_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opWrite_q <= opWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            k_q       <= k_d;
            tocnt_q   <= tocnt_d;
            upWr_q    <= upWr_d;
            upRd_q    <= upRd_d;
        end
    end

    assign bus.up_addr         = addr_q;
    assign bus.up_data_wr      = wdata_q;
    assign bus.up_wr           = upWr_q;
    assign bus.up_rd           = upRd_q;
    assign bus.avs_readdata    = rdata_q;
    assign bus.avs_response    = resp_q;
    assign bus.timeout_cnt     = tocnt_q;
    assign bus.avs_waitrequest = (state_q != DONE);
    assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_up_bus_bridge.sv
// Scoreboard testbench for up_bus_bridge.
// A driver issues directed and random transactions and pushes the predicted
// strobe and completion. A negedge monitor pops and compares them whenever
// the bridge shows a strobe or drops waitrequest.
module tb_up_bus_bridge;

    localparam int          ADDR_W       = 32;
    localparam int          DATA_W       = 32;
    localparam int          RD_LATENCY   = 2;
    localparam int          TIMEOUT      = 64;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [7:0]  tocnt;
        int          doneCyc;
    } doneT;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          strobeCyc;
    } strobeT;

    logic up_clk = 1'b0;
    logic up_rst = 1'b1;
    int   cyc = 0;
    bit   monEnable = 1'b0;

    int vectorsApplied = 0;
    int miscompares = 0;

    doneT   doneQ[$];
    strobeT strobeQ[$];

    logic [31:0] mRdata;
    logic [31:0] mWdata;
    int          mTocnt;

    up_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    up_bus_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LATENCY(RD_LATENCY),
        .TIMEOUT(TIMEOUT),
        .TIMEOUT_DATA(TIMEOUT_DATA)
    ) dut (
        .up_clk(up_clk),
        .up_rst(up_rst),
        .bus(bus)
    );

    always #5 up_clk = ~up_clk;

    always @(posedge up_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failEvent(input string name);
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Reference model for one transaction. The completion wait count is the first
    // k >= MIN at which up_wait is low. The read data is the decoder value in cycle 1+k.
    // The driver then plays the request and the decoder behaviour cycle by cycle.
    task automatic applyStimulus(input bit doRead, input bit doWrite, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waitCycles, input bit stuck);
        logic [31:0] dataArr [TIMEOUT+3];
        int     minK, kdone, lat, c0;
        bit     isWrite, timedOut, seen;
        doneT   d;
        strobeT s;
        for (int i = 0; i < TIMEOUT + 3; i++) dataArr[i] = $urandom;
        isWrite  = doWrite;
        minK     = isWrite ? 1 : RD_LATENCY;
        kdone    = stuck ? TIMEOUT + 1 : ((waitCycles + 1 > minK) ? waitCycles + 1 : minK);
        timedOut = (kdone > TIMEOUT);

        @(posedge up_clk); #1;
        c0 = cyc;
        if (isWrite) mWdata = wdata;
        if (timedOut) begin
            lat = TIMEOUT + 2;
            d.resp = 2'b10;
            if (!isWrite) mRdata = TIMEOUT_DATA;
            if (mTocnt < 255) mTocnt++;
        end else begin
            lat = kdone + 2;
            d.resp = 2'b00;
            if (!isWrite) mRdata = dataArr[1 + kdone];
        end
        d.rdata   = mRdata;
        d.tocnt   = 8'(mTocnt);
        d.doneCyc = c0 + lat;
        s.isWrite   = isWrite;
        s.addr      = addr;
        s.wdata     = mWdata;
        s.strobeCyc = c0 + 1;
        doneQ.push_back(d);
        strobeQ.push_back(s);

        bus.avs_read      = doRead;
        bus.avs_write     = doWrite;
        bus.avs_address   = addr;
        bus.avs_writedata = wdata;
        bus.up_wait       = 1'b0;
        bus.up_data_rd    = dataArr[0];

        seen = 1'b0;
        for (int t = 1; t <= TIMEOUT + 10 && !seen; t++) begin
            @(posedge up_clk); #1;
            bus.up_wait    = stuck || (t >= 2 && t < 2 + waitCycles);
            bus.up_data_rd = (t <= TIMEOUT + 2) ? dataArr[t] : $urandom;
            @(negedge up_clk);
            if (!bus.avs_waitrequest) seen = 1'b1;
        end
        checkOutput("handshake completed", 64'(seen), 64'd1);
    endtask

    task automatic idleCycles(input int n);
        @(posedge up_clk); #1;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        bus.up_wait   = 1'b0;
        repeat (n - 1) @(posedge up_clk);
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rst up_wr", 64'(bus.up_wr), 64'd0);
        checkOutput("rst up_rd", 64'(bus.up_rd), 64'd0);
        checkOutput("rst up_addr", 64'(bus.up_addr), 64'd0);
        checkOutput("rst up_data_wr", 64'(bus.up_data_wr), 64'd0);
        checkOutput("rst avs_readdata", 64'(bus.avs_readdata), 64'd0);
        checkOutput("rst avs_response", 64'(bus.avs_response), 64'd0);
        checkOutput("rst busy", 64'(bus.busy), 64'd0);
        checkOutput("rst timeout_cnt", 64'(bus.timeout_cnt), 64'd0);
        checkOutput("rst avs_waitrequest", 64'(bus.avs_waitrequest), 64'd1);
    endtask

    // Monitor: compare every strobe and every completion against the scoreboard queues.
    always @(negedge up_clk) begin
        if (monEnable) begin
            if (bus.up_wr && bus.up_rd) failEvent("both strobes high");
            if (bus.up_wr || bus.up_rd) begin
                if (strobeQ.size() == 0) begin
                    failEvent("strobe without request");
                end else begin
                    strobeT s;
                    s = strobeQ.pop_front();
                    checkOutput("strobe is write", 64'(bus.up_wr), 64'(s.isWrite));
                    checkOutput("strobe up_addr", 64'(bus.up_addr), 64'(s.addr));
                    checkOutput("strobe up_data_wr", 64'(bus.up_data_wr), 64'(s.wdata));
                    checkOutput("strobe cycle", 64'(cyc), 64'(s.strobeCyc));
                end
            end
            if (!bus.avs_waitrequest) begin
                if (doneQ.size() == 0) begin
                    failEvent("completion without request");
                end else begin
                    doneT d;
                    d = doneQ.pop_front();
                    checkOutput("done avs_readdata", 64'(bus.avs_readdata), 64'(d.rdata));
                    checkOutput("done avs_response", 64'(bus.avs_response), 64'(d.resp));
                    checkOutput("done timeout_cnt", 64'(bus.timeout_cnt), 64'(d.tocnt));
                    checkOutput("done cycle", 64'(cyc), 64'(d.doneCyc));
                    checkOutput("done busy", 64'(bus.busy), 64'd1);
                end
            end
        end
    end

    // Time-limit watchdog so the bench always terminates.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed test-plan cases, random traffic, then counter saturation.
    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.up_data_rd    = '0;
        bus.up_wait       = 1'b0;
        mRdata = '0;
        mWdata = '0;
        mTocnt = 0;

        repeat (3) @(posedge up_clk);
        #1 up_rst = 1'b0;
        @(negedge up_clk);
        checkResetState();
        monEnable = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, 5, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h28, 32'h0, 0, 1'b1);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h34, 32'h1111_2222, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h38, 32'h3333_4444, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h3C, 32'h5555_6666, 3, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h7777_8888, 0, 1'b1);
        idleCycles(2);

        // Reset in the middle of a stuck read: no completion may follow.
        @(posedge up_clk); #1;
        begin
            strobeT s;
            s.isWrite   = 1'b0;
            s.addr      = 32'h44;
            s.wdata     = mWdata;
            s.strobeCyc = cyc + 1;
            strobeQ.push_back(s);
        end
        bus.avs_address = 32'h44;
        bus.avs_read    = 1'b1;
        bus.up_wait     = 1'b1;
        repeat (3) @(posedge up_clk);
        #1 up_rst = 1'b1;
        @(posedge up_clk);
        #1 up_rst = 1'b0;
        bus.avs_read = 1'b0;
        bus.up_wait  = 1'b0;
        mRdata = '0;
        mWdata = '0;
        mTocnt = 0;
        @(negedge up_clk);
        checkResetState();
        repeat (5) @(posedge up_clk);
        applyStimulus(1'b1, 1'b0, 32'h48, 32'h0, 1, 1'b0);
        idleCycles(1);

        for (int n = 0; n < 40; n++) begin
            int op, w, gap;
            op  = int'($urandom_range(0, 3));
            w   = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 6));
            gap = int'($urandom_range(0, 2));
            applyStimulus(op != 0, op == 0 || op == 2, $urandom, $urandom, w, 1'b0);
            if (gap > 0) idleCycles(gap);
        end
        idleCycles(1);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b1, 1'b0, 32'h100 + 32'(n), 32'h0, 0, 1'b1);
        end
        idleCycles(1);
        @(negedge up_clk);
        checkOutput("timeout_cnt saturated", 64'(bus.timeout_cnt), 64'd255);

        idleCycles(4);
        checkOutput("pending completions", 64'(doneQ.size()), 64'd0);
        checkOutput("pending strobes", 64'(strobeQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
